// File: rtl/rv32i_mem_arbiter.sv
// Arbitrates the single registered-output memory port between instruction fetch and data access.
// Data wins by default; an anti-starvation counter forces a fetch grant after STARVE_LIMIT denials.
module rv32i_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        dm_misalign,
  output logic        stall_f,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_ena,
  input  logic [31:0] mem_rd_data
);

  typedef enum logic [1:0] {RESP_NONE, RESP_IF, RESP_DM} resp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
  } mem_req_t;

  resp_t            state, state_nxt;
  logic [CNT_W-1:0] starve, starve_nxt;
  logic [31:0]      if_hold, dm_hold;
  logic             starve_hit, gnt_if, gnt_dm;
  mem_req_t         mreq;

  assign starve_hit = (starve == CNT_W'(STARVE_LIMIT));

  always_comb begin
    gnt_dm = rst && ena && dm_req && !(if_req && starve_hit);
    gnt_if = rst && ena && if_req && !gnt_dm;
  end

  assign if_gnt  = gnt_if;
  assign dm_gnt  = gnt_dm;
  assign stall_f = if_req && !gnt_if;

  always_comb begin
    mreq = '0;
    if (gnt_if) begin
      mreq.addr = if_addr;
    end else if (gnt_dm) begin
      mreq.addr  = dm_addr;
      mreq.wdata = dm_wdata;
      mreq.we    = dm_we;
    end
  end

  assign mem_addr    = mreq.addr;
  assign mem_wr_data = mreq.wdata;
  assign mem_wr_ena  = mreq.we;

  // Counter freezes while disabled so a pause does not forgive or punish fetch.
  always_comb begin
    starve_nxt = starve;
    if (ena) begin
      if (if_req && !gnt_if) starve_nxt = starve_hit ? starve : starve + 1'b1;
      else                   starve_nxt = '0;
    end
  end

  always_comb begin
    state_nxt = RESP_NONE;
    if (gnt_if)              state_nxt = RESP_IF;
    else if (gnt_dm && !dm_we) state_nxt = RESP_DM;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RESP_NONE;
      starve      <= '0;
      if_hold     <= '0;
      dm_hold     <= '0;
      dm_misalign <= 1'b0;
    end else begin
      state  <= state_nxt;
      starve <= starve_nxt;
      if (state == RESP_IF) if_hold <= mem_rd_data;
      if (state == RESP_DM) dm_hold <= mem_rd_data;
      if (gnt_dm) dm_misalign <= (dm_addr[1:0] != 2'b00);
    end
  end

  assign if_rvalid = (state == RESP_IF);
  assign dm_rvalid = (state == RESP_DM);
  // Data is visible in the rvalid cycle itself; the hold register keeps it afterwards.
  assign if_rdata  = if_rvalid ? mem_rd_data : if_hold;
  assign dm_rdata  = dm_rvalid ? mem_rd_data : dm_hold;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed plus randomized bench for rv32i_mem_arbiter against a transaction-level reference model.
module tb_rv32i_mem_arbiter;
  localparam int LIMIT = 4;

  logic        clk, rst, ena;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid, dm_misalign;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        stall_f, mem_wr_ena;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;

  rv32i_mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_misalign(dm_misalign), .stall_f(stall_f),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_ena(mem_wr_ena), .mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] seed(input logic [7:0] idx);
    return ({24'd0, idx} * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  // Registered-output memory model seen by the DUT
  logic [31:0] mem [256];
  logic        mem_wr [256];
  always @(posedge clk) begin
    mem_rd_data <= (mem_wr[mem_addr[9:2]] === 1'b1) ? mem[mem_addr[9:2]] : seed(mem_addr[9:2]);
    if (mem_wr_ena) begin
      mem[mem_addr[9:2]]    <= mem_wr_data;
      mem_wr[mem_addr[9:2]] <= 1'b1;
    end
  end

  // Reference model state
  logic [31:0] ref_mem [256];
  logic        ref_wr [256];
  int          m_starve, m_resp, deny_run, max_deny;
  logic [31:0] m_data, m_if_hold, m_dm_hold;
  logic        m_mis, e_if_win, e_dm_win;
  int          passed, failed, total;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return (ref_wr[a[9:2]] === 1'b1) ? ref_mem[a[9:2]] : seed(a[9:2]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_starve = 0; m_resp = 0; m_data = 0; m_if_hold = 0; m_dm_hold = 0; m_mis = 0; deny_run = 0;
  endtask

  task automatic cyc(input logic r, input logic e, input logic ir, input logic [31:0] ia,
                     input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    rst = r; ena = e; if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd;
    if (!r) model_reset();
    e_dm_win = r && e && dr && !(ir && m_starve == LIMIT);
    e_if_win = r && e && ir && !e_dm_win;
    #1;
    chk("if_gnt", {31'd0, if_gnt}, {31'd0, e_if_win});
    chk("dm_gnt", {31'd0, dm_gnt}, {31'd0, e_dm_win});
    chk("stall_f", {31'd0, stall_f}, {31'd0, ir && !e_if_win});
    chk("mem_addr", mem_addr, e_if_win ? ia : (e_dm_win ? da : 32'd0));
    chk("mem_wr_ena", {31'd0, mem_wr_ena}, {31'd0, e_dm_win && dw});
    if (!e_if_win) chk("mem_wr_data", mem_wr_data, e_dm_win ? dd : 32'd0);
    chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, m_resp == 1});
    chk("dm_rvalid", {31'd0, dm_rvalid}, {31'd0, m_resp == 2});
    chk("if_rdata", if_rdata, (m_resp == 1) ? m_data : m_if_hold);
    chk("dm_rdata", dm_rdata, (m_resp == 2) ? m_data : m_dm_hold);
    chk("dm_misalign", {31'd0, dm_misalign}, {31'd0, m_mis});
    @(posedge clk);
    if (r) begin
      if (m_resp == 1) m_if_hold = m_data;
      if (m_resp == 2) m_dm_hold = m_data;
      m_resp = 0;
      if (e_if_win) begin
        m_resp = 1; m_data = ref_rd(ia);
      end else if (e_dm_win) begin
        m_data = ref_rd(da);
        m_resp = dw ? 0 : 2;
        if (dw) begin ref_mem[da[9:2]] = dd; ref_wr[da[9:2]] = 1'b1; end
        m_mis = (da[1:0] != 2'b00);
      end
      if (e) begin
        if (ir && !e_if_win) begin
          m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
          deny_run++;
          if (deny_run > max_deny) max_deny = deny_run;
        end else begin
          m_starve = 0; deny_run = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  logic        p_if, p_dm, p_we;
  logic [31:0] p_ia, p_da, p_dd;
  int          if_gnts, dm_gnts;

  initial begin
    passed = 0; failed = 0; total = 0; max_deny = 0;
    for (int i = 0; i < 256; i++) ref_wr[i] = 1'b0;
    model_reset();
    rst = 0; ena = 0; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    @(posedge clk); @(negedge clk);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);

    // Fetch only
    cyc(1, 1, 1, 32'h0, 0, 0, 0, 0);
    cyc(1, 1, 1, 32'h4, 0, 0, 0, 0);
    cyc(1, 1, 1, 32'h8, 0, 0, 0, 0);
    cyc(1, 1, 0, 32'h0, 0, 0, 0, 0);

    // Conflict: data wins, fetch follows
    cyc(1, 1, 1, 32'hC, 1, 0, 32'h100, 0);
    cyc(1, 1, 1, 32'hC, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);

    // Starvation: data held busy, fetch held requesting
    p_ia = 32'h10; if_gnts = 0; dm_gnts = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 1, p_ia, 1, 0, 32'h200 + 32'(i * 4), 0);
      if (e_if_win) begin p_ia += 4; if_gnts++; end
      if (e_dm_win) dm_gnts++;
    end
    chk("starve_if_gnts", if_gnts, 2);
    chk("starve_dm_gnts", dm_gnts, 8);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);

    // Store then load back
    cyc(1, 1, 0, 0, 1, 1, 32'h40, 32'hDEAD_BEEF);
    cyc(1, 1, 0, 0, 1, 0, 32'h40, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    chk("store_readback", dm_rdata, 32'hDEAD_BEEF);

    // Misaligned load, then disabled with fetch pending
    cyc(1, 1, 0, 0, 1, 0, 32'h102, 0);
    cyc(1, 0, 1, 32'h20, 0, 0, 0, 0);
    cyc(1, 0, 1, 32'h20, 0, 0, 0, 0);
    cyc(1, 0, 1, 32'h20, 0, 0, 0, 0);
    cyc(1, 1, 1, 32'h20, 0, 0, 0, 0);

    // Reset while a fetch response is in flight
    cyc(1, 1, 1, 32'h24, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);

    // Randomized traffic honoring hold-until-grant
    p_if = 0; p_dm = 0; p_we = 0; p_ia = 0; p_da = 0; p_dd = 0;
    for (int i = 0; i < 400; i++) begin
      if (!p_if && ($urandom_range(3) != 0)) begin p_if = 1; p_ia = $urandom; end
      if (!p_dm && ($urandom_range(2) != 0)) begin
        p_dm = 1; p_we = $urandom_range(1); p_da = $urandom; p_dd = $urandom;
      end
      cyc((i % 97) != 96, $urandom_range(7) != 0, p_if, p_ia, p_dm, p_we, p_da, p_dd);
      if (e_if_win || !rst) p_if = 0;
      if (e_dm_win || !rst) p_dm = 0;
    end
    chk("max_fetch_denials", max_deny, LIMIT);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
